// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_buffer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // True when the byte address falls on an instruction-word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr & (WORD_BYTES - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/fb_fifo.sv
// Circular instruction buffer: DEPTH entries of {instr, pc}, flush empties it.
module fb_fifo
    import fetch_buffer_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fetch_entry_t     mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flush overrides both push and pop so the buffer is always empty afterwards.
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch front end: issues credit-limited reads to a 1-cycle instruction memory
// and buffers the returned words for the decode stage.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [31:0] pc_in,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        misalign_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fb_state_t        state;
    logic             req_vld_p1;
    logic [31:0]      req_addr_p1;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             credit_ok;
    logic             issue;
    logic             misaligned;
    fetch_entry_t     head;
    fetch_entry_t     push_data;

    // A slot is reserved for every outstanding read, so the buffer can never overflow.
    assign credit_ok  = (count + CNT_W'(req_vld_p1)) < CNT_W'(DEPTH);
    assign issue      = (state == ST_RUN) && credit_ok && !flush;
    assign misaligned = !is_word_aligned(pc_in);

    assign imem_req  = issue && !misaligned;
    // While booting the bus shows the reset vector, the first address the PC will present.
    assign imem_addr = (state == ST_BOOT) ? RESET_VECTOR : pc_in;
    assign pc_stall  = (state == ST_RUN) ? !imem_req : 1'b1;

    // A response returning in a flush cycle is stale; the FIFO drops it.
    assign push      = req_vld_p1;
    assign push_data = '{instr: imem_rdata, pc: req_addr_p1};
    assign pop       = id_valid && id_ready;

    assign id_valid = !empty;
    assign id_instr = empty ? 32'd0 : head.instr;
    assign id_pc    = empty ? 32'd0 : head.pc;

    // Control FSM: one idle boot cycle, then fetch until a misaligned issue halts it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= ST_BOOT;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (issue && misaligned) begin
                        misalign_err <= 1'b1;
                        state        <= ST_HALT;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_BOOT;
            endcase
        end
    end

    // Request stage -> response stage: track the outstanding read.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) req_vld_p1 <= 1'b0;
        else         req_vld_p1 <= imem_req;
    end

    // Request stage -> response stage: address travelling with the read.
    always_ff @(posedge clk) begin
        if (imem_req) req_addr_p1 <= pc_in;
    end

    fb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n) push |-> !full)
        else $error("fetch_buffer: push into full FIFO");

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH = 2).
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    int          req_cnt = 0;
    int          bad_addr_cnt = 0;
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    fetch_buffer #(.DEPTH(2), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .pc_in        (pc_in),
        .pc_stall     (pc_stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // Instruction ROM contents: word at address a is 0xA500_0000 | a.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom(imem_addr);
    end

    // Mid-cycle monitor of issued reads and decode handshakes.
    always @(negedge clk) begin
        if (arst_n && imem_req) begin
            req_cnt = req_cnt + 1;
            if (imem_addr[1:0] != 2'b00) bad_addr_cnt = bad_addr_cnt + 1;
        end
        if (id_valid && id_ready) begin
            pop_pc.push_back(id_pc);
            pop_instr.push_back(id_instr);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        req_cnt      = 0;
        bad_addr_cnt = 0;
        pop_pc.delete();
        pop_instr.delete();
    endtask

    // One clock: PC model advances by 4 when the cycle was not stalled.
    task automatic tick();
        logic stall;
        @(negedge clk);
        stall = pc_stall;
        @(posedge clk);
        #1;
        if (!stall) pc_in = pc_in + 32'd4;
    endtask

    // Pulse reset across an edge and release just after the next edge (BOOT cycle follows).
    task automatic do_reset();
        @(posedge clk);
        #1;
        arst_n   = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
        pc_in    = 32'd0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_pops(input int n, input string name);
        for (int i = 0; i < 30 && pop_pc.size() < n; i++) tick();
        checks++;
        if (pop_pc.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: pops %0d required %0d", name, pop_pc.size(), n);
        end
    endtask

    task automatic test_reset();
        #3 arst_n = 1'b0;
        #1;
        checks++;
        if ({id_valid, imem_req, pc_stall, misalign_err} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0010", {id_valid, imem_req, pc_stall, misalign_err});
        end
        checks++;
        if ({id_instr, id_pc} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {id_instr, id_pc});
        end
        @(posedge clk);
        #1 arst_n = 1'b1;
        clear_logs();
        #3;
        checks++;
        if ({imem_req, pc_stall} !== 2'b01) begin
            errors++;
            $display("FAIL boot_idle: req/stall %b required 01", {imem_req, pc_stall});
        end
        tick();
        #3;
        checks++;
        if ({imem_req, pc_stall} !== 2'b10 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL run_first_req: req/stall %b addr %h required 10 addr 0", {imem_req, pc_stall}, imem_addr);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc[3]    = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_instr[3] = '{32'hA500_0000, 32'hA500_0004, 32'hA500_0008};
        do_reset();
        id_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: id_valid %b required 0 after 2 edges", id_valid);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hA500_0000) begin
            errors++;
            $display("FAIL latency_first: valid %b pc %h instr %h required 1 0 a5000000", id_valid, id_pc, id_instr);
        end
        wait_pops(3, "basic");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_pc[i] !== exp_pc[i] || pop_instr[i] !== exp_instr[i]) begin
                errors++;
                $display("FAIL basic_seq[%0d]: pc %h instr %h required %h %h", i, pop_pc[i], pop_instr[i], exp_pc[i], exp_instr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int unstable = 0;
        do_reset();
        id_ready = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hA500_0000) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL hold_stable: unstable cycles %0d required 0", unstable);
        end
        checks++;
        if (req_cnt != 2) begin
            errors++;
            $display("FAIL hold_req_cnt: got %0d required 2", req_cnt);
        end
        checks++;
        if ({pc_stall, imem_req} !== 2'b10) begin
            errors++;
            $display("FAIL hold_stall: stall/req %b required 10", {pc_stall, imem_req});
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'hA500_0004) begin
            errors++;
            $display("FAIL hold_second: valid %b pc %h instr %h required 1 4 a5000004", id_valid, id_pc, id_instr);
        end
        wait_pops(3, "release");
        checks++;
        if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin
            errors++;
            $display("FAIL release_order: got %h %h %h required 0 4 8", pop_pc[0], pop_pc[1], pop_pc[2]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        id_ready = 1'b0;
        tick();
        tick();
        tick();
        flush = 1'b1;
        pc_in = 32'h40;
        #2;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_req: imem_req %b required 0", imem_req);
        end
        tick();
        flush    = 1'b0;
        id_ready = 1'b1;
        #1;
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: id_valid %b required 0", id_valid);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL flush_resume: req %b addr %h required 1 40", imem_req, imem_addr);
        end
        wait_pops(1, "flush");
        checks++;
        if (pop_pc[0] !== 32'h40 || pop_instr[0] !== 32'hA500_0040) begin
            errors++;
            $display("FAIL flush_next: pc %h instr %h required 40 a5000040", pop_pc[0], pop_instr[0]);
        end
    endtask

    task automatic test_flush_pop();
        do_reset();
        id_ready = 1'b1;
        tick();
        tick();
        tick();
        flush = 1'b1;
        pc_in = 32'h80;
        tick();
        flush = 1'b0;
        checks++;
        if (pop_pc.size() != 1 || pop_pc[0] !== 32'h0) begin
            errors++;
            $display("FAIL flush_pop_count: pops %0d first %h required 1 0", pop_pc.size(), pop_pc[0]);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pop_empty: id_valid %b required 0", id_valid);
        end
        wait_pops(2, "flush_pop");
        checks++;
        if (pop_pc[1] !== 32'h80) begin
            errors++;
            $display("FAIL flush_pop_next: pc %h required 80", pop_pc[1]);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        id_ready = 1'b0;
        tick();
        tick();
        pc_in = 32'h6;
        #2;
        checks++;
        if ({imem_req, pc_stall} !== 2'b01) begin
            errors++;
            $display("FAIL misalign_block: req/stall %b required 01", {imem_req, pc_stall});
        end
        tick();
        checks++;
        if (misalign_err !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL misalign_set: err %b valid %b pc %h required 1 1 0", misalign_err, id_valid, id_pc);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (pop_pc.size() != 1 || pop_pc[0] !== 32'h0) begin
            errors++;
            $display("FAIL halt_drain: pops %0d first %h required 1 0", pop_pc.size(), pop_pc[0]);
        end
        checks++;
        if (req_cnt != 1 || bad_addr_cnt != 0) begin
            errors++;
            $display("FAIL halt_no_req: reqs %0d misaligned reqs %0d required 1 0", req_cnt, bad_addr_cnt);
        end
        checks++;
        if ({misalign_err, pc_stall, imem_req, id_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL halt_hold: err/stall/req/valid %b required 1100", {misalign_err, pc_stall, imem_req, id_valid});
        end
        @(posedge clk);
        #1 arst_n = 1'b0;
        #1;
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: misalign_err %b required 0", misalign_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        id_ready = 1'b1;
        tick();
        tick();
        arst_n = 1'b0;
        #1;
        checks++;
        if ({id_valid, imem_req} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_out: valid/req %b required 00", {id_valid, imem_req});
        end
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        pc_in  = 32'h20;
        clear_logs();
        tick();
        tick();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_push: id_valid %b required 0", id_valid);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'hA500_0020) begin
            errors++;
            $display("FAIL midreset_new: valid %b pc %h instr %h required 1 20 a5000020", id_valid, id_pc, id_instr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_flush_pop();
        test_misalign();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
